// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial line of the UART transmitter.
// The master drives the word; the transmitter (slave) drives the line.
interface uart_tx_if #(
  parameter int width = 8
);
  logic [width-1:0] P_DATA;
  logic             Data_Valid;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic             TX_OUT;
  logic             Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one frame bit per CLK, LSB-first data, optional parity.
// TX_OUT and Busy are registered and describe the state being entered at each edge.
module uart_tx #(
  parameter int width = 8
) (
  input  logic     CLK,
  input  logic     Reset,
  uart_tx_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int CNT_W = (width > 1) ? $clog2(width) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);

  // Parity is resolved at accept time so the line bit is ready when PARITY is entered.
  function automatic logic parity_bit(input logic [width-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [width-1:0] shreg_q, shreg_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [width-1:0] shreg_next;

  assign shreg_next = shreg_q >> 1;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = 1'b1;

    case (state_q)
      IDLE, STOP: begin
        if (bus.Data_Valid) begin
          state_d   = START;
          shreg_d   = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          par_bit_d = parity_bit(bus.P_DATA, bus.PAR_TYP);
          cnt_d     = '0;
          tx_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = shreg_q[0];
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          state_d = par_en_q ? PARITY : STOP;
          tx_d    = par_en_q ? par_bit_q : 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          shreg_d = shreg_next;
          tx_d    = shreg_next[0];
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: driver pushes expected frame bits on acceptance,
// a negedge monitor pops and compares whenever the line is busy.
module tb_uart_tx;
  localparam int W = 8;

  logic CLK = 1'b0;
  logic Reset = 1'b0;

  uart_tx_if #(.width(W)) bus ();

  uart_tx #(.width(W)) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit cap[$];
  int rem = 0;
  bit mon_e;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame per the line rules: start 0, data LSB first, optional parity, stop 1.
  task automatic push_frame(input logic [W-1:0] d, input bit pe, input bit pt);
    int ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < W; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pe) begin
      if (pt == 1'b0) exp_q.push_back((ones % 2) == 1);
      else            exp_q.push_back((ones % 2) == 0);
    end
    exp_q.push_back(1'b1);
    rem = W + 2 + (pe ? 1 : 0);
  endtask

  // rem = frame cycles still to be shown, counting the one that starts at this edge.
  task automatic model_edge();
    if (bus.Data_Valid && rem <= 1) push_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
    else if (rem > 0) rem--;
  endtask

  task automatic drive(input bit dv, input logic [W-1:0] d, input bit pe, input bit pt);
    @(negedge CLK);
    bus.Data_Valid = dv;
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    @(posedge CLK);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, W'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic check_frame(input string name, input bit e[], input int n);
    check(cap.size() == n, {name, "_len"}, cap.size(), n);
    if (cap.size() == n)
      for (int i = 0; i < n; i++) check(cap[i] == e[i], {name, "_bit"}, int'(cap[i]), int'(e[i]));
  endtask

  always @(negedge CLK) begin
    if (!Reset) begin
      check(bus.TX_OUT == 1'b1, "reset_tx", int'(bus.TX_OUT), 1);
      check(bus.Busy == 1'b0, "reset_busy", int'(bus.Busy), 0);
    end else if (bus.Busy) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "busy_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check(bus.TX_OUT == mon_e, "tx_bit", int'(bus.TX_OUT), int'(mon_e));
      end
      cap.push_back(bus.TX_OUT);
    end else begin
      check(bus.TX_OUT == 1'b1, "idle_tx", int'(bus.TX_OUT), 1);
      check(exp_q.size() == 0, "busy_dropped_pending", exp_q.size(), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit f1[] = '{0,1,0,1,0,0,1,0,1,1};
    bit f4[] = '{0,1,1,1,1,0,0,0,0,1};
    bit f5[] = '{0,1,0,0,0,0,0,0,1,1};
    int guard;

    bus.Data_Valid = 1'b0;
    bus.P_DATA     = '0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    #12;
    check(bus.TX_OUT == 1'b1, "por_tx", int'(bus.TX_OUT), 1);
    check(bus.Busy == 1'b0, "por_busy", int'(bus.Busy), 0);
    @(negedge CLK);
    Reset = 1'b1;
    idle(3);

    // Plain frame, no parity
    cap.delete();
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    idle(12);
    check_frame("a5_nopar", f1, 10);

    // Parity frames: even/odd on 0xA5, even on 0x07
    cap.delete();
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    idle(12);
    check(cap.size() == 11, "a5_even_len", cap.size(), 11);
    if (cap.size() == 11) check(cap[9] == 1'b0, "a5_even_par", int'(cap[9]), 0);
    cap.delete();
    drive(1'b1, 8'hA5, 1'b1, 1'b1);
    idle(12);
    check(cap.size() == 11, "a5_odd_len", cap.size(), 11);
    if (cap.size() == 11) check(cap[9] == 1'b1, "a5_odd_par", int'(cap[9]), 1);
    cap.delete();
    drive(1'b1, 8'h07, 1'b1, 1'b0);
    idle(12);
    check(cap.size() == 11, "07_even_len", cap.size(), 11);
    if (cap.size() == 11) check(cap[9] == 1'b1, "07_even_par", int'(cap[9]), 1);

    // Back-to-back: new word offered in the STOP cycle
    cap.delete();
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    guard = 0;
    while (rem != 1 && guard < 20) begin
      idle(1);
      guard++;
    end
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    idle(12);
    check(cap.size() == 20, "b2b_busy_cycles", cap.size(), 20);

    // Data_Valid during data bit 3 is dropped; input churn has no effect
    cap.delete();
    drive(1'b1, 8'h0F, 1'b0, 1'b0);
    idle(4);
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    repeat (3) drive(1'b0, W'($urandom), 1'b1, 1'b1);
    idle(8);
    check_frame("0f_ignore55", f4, 10);

    // Asynchronous reset during data bit 4, release with Data_Valid high
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    idle(5);
    #2;
    Reset = 1'b0;
    exp_q.delete();
    rem = 0;
    #1;
    check(bus.TX_OUT == 1'b1, "async_rst_tx", int'(bus.TX_OUT), 1);
    check(bus.Busy == 1'b0, "async_rst_busy", int'(bus.Busy), 0);
    repeat (2) @(posedge CLK);
    cap.delete();
    @(negedge CLK);
    bus.Data_Valid = 1'b1;
    bus.P_DATA     = 8'h81;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    Reset          = 1'b1;
    @(posedge CLK);
    model_edge();
    idle(11);
    check_frame("81_after_rst", f5, 10);

    // Data_Valid held high with parity: three contiguous 11-cycle frames
    cap.delete();
    repeat (33) drive(1'b1, W'($urandom), 1'b1, 1'($urandom));
    idle(3);
    check(cap.size() == 33, "held_dv_busy_cycles", cap.size(), 33);

    // Random traffic
    repeat (300) drive($urandom_range(0, 3) == 0, W'($urandom), 1'($urandom), 1'($urandom));
    idle(15);
    check(exp_q.size() == 0, "drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter for the link's TX path. It accepts a parallel word with a one-cycle valid strobe and serializes it LSB-first. The frame is start bit, data bits, optional parity bit, then stop bit. CLK is the TX bit-rate clock, so each frame bit occupies exactly one CLK cycle; the baud-rate clock divider sits upstream of this block.

Parameters:
width, 8, number of data bits per frame

Ports:
CLK  input  1  TX bit-rate clock, rising-edge active
Reset  input  1  asynchronous, active-low reset
P_DATA  input  width  parallel data word to transmit
Data_Valid  input  1  one-cycle strobe: P_DATA and the config inputs are valid
PAR_EN  input  1  1 = insert parity bit after the data bits
PAR_TYP  input  1  0 = even parity, 1 = odd parity
TX_OUT  output  1  serial line output, idles high
Busy  output  1  high while a frame is on the line

Behaviour:
- Reset (CLK and Reset are the decided clock and reset): Reset low forces TX_OUT=1, Busy=0, state IDLE, bit counter 0, shift register 0. Effect is immediate, including mid-frame; the partial frame is abandoned and never resumed.
- TX_OUT and Busy are registered outputs, with no combinational path from any input.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0.
  - Data_Valid=1 at a rising edge: latch P_DATA, PAR_EN and PAR_TYP into internal registers, go to START.
  - TX_OUT=0 and Busy=1 from that edge onward (latency: 1 cycle from the accepting edge to the start bit).
- START: TX_OUT=0 for 1 cycle, then go to DATA.
- DATA: TX_OUT = latched bit i for i = 0 .. width-1, LSB first, one cycle each. A counter of ceil(log2(width)) bits tracks i.
  - After bit width-1: go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: TX_OUT = ^data when PAR_TYP=0, or ~^data when PAR_TYP=1, for 1 cycle. Parity is computed from the latched word. Then go to STOP.
- STOP: TX_OUT=1 for 1 cycle.
  - Data_Valid=1 at the edge ending STOP: accept a new word, go straight to START. Busy stays 1 with no idle gap (back-to-back frames).
  - Otherwise: go to IDLE, Busy=0.
- Frame length: width+2 cycles without parity, width+3 with parity (10 or 11 for width=8).
- Data_Valid in START, DATA or PARITY: ignored. The word is dropped with no error flag; upstream must respect Busy.
- P_DATA, PAR_EN and PAR_TYP changes after acceptance have no effect on the current frame.
- Data_Valid held high continuously: a new word is accepted at every IDLE or STOP edge.
- Reset deasserted while Data_Valid=1: the first rising edge after deassertion accepts normally.

Test Plan:
1. Reset, then P_DATA=0xA5, PAR_EN=0, Data_Valid pulse -> TX_OUT over 10 cycles = 0,1,0,1,0,0,1,0,1,1; Busy=1 for exactly those 10 cycles, then 0.
2. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0, 11-cycle frame. Repeat with PAR_TYP=1 -> parity bit 1. With 0x07 and even parity -> parity bit 1.
3. 0x3C accepted, then Data_Valid with 0xFF during the STOP cycle -> stop bit 1, next cycle start bit 0, then eight 1s and stop. Busy never drops between frames.
4. Data_Valid with 0x55 during data bit 3 of an ongoing 0x0F frame, and P_DATA altered mid-frame -> 0x0F frame unchanged, 0x55 never transmitted, line idles after stop.
5. Reset asserted during data bit 4 -> TX_OUT=1 and Busy=0 asynchronously. A new 0x81 after release -> full frame 0,1,0,0,0,0,0,0,1,1.
6. Data_Valid held high with PAR_EN=1 for 3 frames -> 33 consecutive frame cycles, Busy continuously 1, each frame 11 cycles with a correct parity bit.
